dbg_slave_sysclk_cmd_sync: RTL and testbench

Parametrised system-clock side of the JTAG debug slave: the next generation of the fixed 2-bit-IR / 38-bit-DR sysclk stage. It synchronises the TCK-domain update strobes (vs_uir, vs_udr) into clk and captures the shifted data register into jdo. It decodes the captured IR into per-command take_action / take_no_action strobes. New over the previous generation: parametrised IR/DR width and synchroniser depth, a cmd_ready back-pressure handshake with the CPU debug logic, and overrun detection.

---
 rtl/dbg_slave_sysclk_cmd_sync.sv | 146 ++++++++++++++
 tb/tb_dbg_slave_sysclk_cmd_sync.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_slave_sysclk_cmd_sync.sv
// System-clock side of the JTAG debug slave: strobe synchronisation, DR capture, command issue.
// Optional build macro DBG_SLAVE_OVERRUN_CNT_EN adds a saturating 8-bit overrun_cnt output.

module dbg_slave_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];
endmodule

module dbg_slave_sysclk_cmd_sync #(
  parameter  int IR_WIDTH    = 2,
  parameter  int DR_WIDTH    = 38,
  parameter  int SYNC_STAGES = 2,
  parameter  int ACTION_BIT  = 37,
  localparam int NUM_CMD     = 2**IR_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [DR_WIDTH-1:0] sr,
  input  logic                vs_uir,
  input  logic                vs_udr,
  input  logic                cmd_ready,
  input  logic                overrun_clr,
  output logic [DR_WIDTH-1:0] jdo,
  output logic [IR_WIDTH-1:0] cmd_ir,
  output logic [NUM_CMD-1:0]  take_action,
  output logic [NUM_CMD-1:0]  take_no_action,
  output logic                cmd_pending,
  output logic                overrun
`ifdef DBG_SLAVE_OVERRUN_CNT_EN
  ,
  output logic [7:0]          overrun_cnt
`endif
);
  typedef enum logic {IDLE, ISSUE} state_t;

  // bit 0: update-IR, bit 1: update-DR
  logic [1:0] vs_raw, vs_sync, vs_d, vs_edge;
  logic       uir_edge, udr_edge;

  assign vs_raw = {vs_udr, vs_uir};

  for (genvar g = 0; g < 2; g++) begin : g_sync
    dbg_slave_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (vs_raw[g]),
      .q       (vs_sync[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vs_d <= '0;
    else          vs_d <= vs_sync;
  end

  assign vs_edge  = vs_sync & ~vs_d;
  assign uir_edge = vs_edge[0];
  assign udr_edge = vs_edge[1];

  state_t state_q, state_d;
  logic   capture, issue, drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    issue   = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: if (udr_edge) begin
        capture = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        drop = udr_edge;
        if (cmd_ready) begin
          issue   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_pending = (state_q == ISSUE);

  logic [IR_WIDTH-1:0] ir_q;
  logic [NUM_CMD-1:0]  cmd_onehot;

  assign cmd_onehot = NUM_CMD'(1) << cmd_ir;

  // cmd_ir binds the IR held before this cycle, so a coincident update-IR only affects later commands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q           <= '0;
      jdo            <= '0;
      cmd_ir         <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      overrun        <= 1'b0;
    end else begin
      if (uir_edge) ir_q <= ir_in;
      if (capture) begin
        jdo    <= sr;
        cmd_ir <= ir_q;
      end
      if (issue) begin
        take_action    <= jdo[ACTION_BIT] ? cmd_onehot : '0;
        take_no_action <= jdo[ACTION_BIT] ? '0 : cmd_onehot;
      end else begin
        take_action    <= '0;
        take_no_action <= '0;
      end
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

`ifdef DBG_SLAVE_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overrun_cnt <= '0;
    else if (drop) begin
      if (overrun_clr)               overrun_cnt <= 8'd1;
      else if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end else if (overrun_clr) overrun_cnt <= '0;
  end
`endif
endmodule

// File: tb/tb_dbg_slave_sysclk_cmd_sync.sv
// Randomised bench for dbg_slave_sysclk_cmd_sync with a command-level reference model.
// Build with DBG_SLAVE_OVERRUN_CNT_EN defined to also check overrun_cnt.

module tb_dbg_slave_sysclk_cmd_sync;
  localparam int IRW = 2;
  localparam int DRW = 38;
  localparam int S   = 2;
  localparam int AB  = 37;
  localparam int NC  = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [IRW-1:0] ir_in = '0;
  logic [DRW-1:0] sr = '0;
  logic           vs_uir = 1'b0, vs_udr = 1'b0, cmd_ready = 1'b0, overrun_clr = 1'b0;
  logic [DRW-1:0] jdo;
  logic [IRW-1:0] cmd_ir;
  logic [NC-1:0]  take_action, take_no_action;
  logic           cmd_pending, overrun;
`ifdef DBG_SLAVE_OVERRUN_CNT_EN
  logic [7:0]     overrun_cnt;
`endif

  dbg_slave_sysclk_cmd_sync #(
    .IR_WIDTH(IRW), .DR_WIDTH(DRW), .SYNC_STAGES(S), .ACTION_BIT(AB)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ir_in          (ir_in),
    .sr             (sr),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .cmd_ready      (cmd_ready),
    .overrun_clr    (overrun_clr),
    .jdo            (jdo),
    .cmd_ir         (cmd_ir),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .cmd_pending    (cmd_pending),
    .overrun        (overrun)
`ifdef DBG_SLAVE_OVERRUN_CNT_EN
    ,
    .overrun_cnt    (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int strobe_seen = 0;
  bit rnd_ready = 0, rnd_clr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples of the TCK levels per clk edge; an edge takes effect S clks after
  // the first high sample following a low one.
  bit             uh[$], dh[$];
  logic [IRW-1:0] m_ir = '0, m_cmd_ir = '0;
  logic [DRW-1:0] m_jdo = '0;
  logic [NC-1:0]  m_ta = '0, m_tna = '0;
  bit             m_pend = 0, m_ovr = 0;
  int             m_cnt = 0;

  task automatic model_reset();
    uh.delete(); dh.delete();
    m_ir = '0; m_cmd_ir = '0; m_jdo = '0; m_ta = '0; m_tna = '0;
    m_pend = 0; m_ovr = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int n;
    bit ue, de, was_pend, dropped;
    uh.push_back(vs_uir); dh.push_back(vs_udr);
    n = uh.size() - 1;
    ue = (n >= S) && uh[n-S] && ((n-S-1 < 0) || !uh[n-S-1]);
    de = (n >= S) && dh[n-S] && ((n-S-1 < 0) || !dh[n-S-1]);
    was_pend = m_pend;
    dropped  = was_pend && de;
    m_ta = '0; m_tna = '0;
    if (!was_pend) begin
      if (de) begin m_jdo = sr; m_cmd_ir = m_ir; m_pend = 1; end
    end else if (cmd_ready) begin
      if (m_jdo[AB]) m_ta[m_cmd_ir] = 1'b1;
      else           m_tna[m_cmd_ir] = 1'b1;
      m_pend = 0;
    end
    if (dropped)          m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    if (dropped)          m_cnt = overrun_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    else if (overrun_clr) m_cnt = 0;
    if (ue) m_ir = ir_in;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_reset();
    else          model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("jdo", jdo, m_jdo);
    chk("cmd_ir", cmd_ir, m_cmd_ir);
    chk("take_action", take_action, m_ta);
    chk("take_no_action", take_no_action, m_tna);
    chk("cmd_pending", cmd_pending, m_pend);
    chk("overrun", overrun, m_ovr);
    chk("strobe_onehot", ($countones({take_action, take_no_action}) <= 1), 1);
`ifdef DBG_SLAVE_OVERRUN_CNT_EN
    chk("overrun_cnt", overrun_cnt, m_cnt);
`endif
    if (|{take_action, take_no_action}) strobe_seen++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      if (rnd_ready) cmd_ready   = ($urandom_range(0, 2) != 0);
      if (rnd_clr)   overrun_clr = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic pulse_uir(input logic [IRW-1:0] ir, input int hi, input int lo);
    ir_in = ir; vs_uir = 1'b1; tick(hi); vs_uir = 1'b0; tick(lo);
  endtask

  task automatic dr_cmd(input logic [DRW-1:0] d, input int hi, input int lo);
    sr = d; vs_udr = 1'b1; tick(hi); vs_udr = 1'b0; tick(lo);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("rst_jdo", jdo, 0);
      chk("rst_strobes", {take_action, take_no_action}, 0);
      chk("rst_pending", cmd_pending, 0);
      chk("rst_overrun", overrun, 0);
    end

    // basic action: jdo two edges after first sample, strobe one edge later
    cmd_ready = 1'b1;
    pulse_uir(2'd2, 2, 3);
    sr = 38'h20_0000_1234; vs_udr = 1'b1;
    tick(1); chk("basic_jdo_k", jdo, 0);
    tick(1); chk("basic_jdo_k1", jdo, 0); vs_udr = 1'b0;
    tick(1); chk("basic_jdo_k2", jdo, 38'h20_0000_1234); chk("basic_ta_k2", take_action, 0);
    tick(1); chk("basic_ta_k3", take_action, 4'b0100); chk("basic_tna_k3", take_no_action, 0);
    tick(1); chk("basic_ta_k4", take_action, 0);

    // no-action with back-pressure
    cmd_ready = 1'b0;
    pulse_uir(2'd1, 2, 3);
    dr_cmd(38'h00_0000_0055, 2, 2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_pending", cmd_pending, 1);
      chk("bp_no_strobe", {take_action, take_no_action}, 0);
      tick(1);
    end
    cmd_ready = 1'b1;
    tick(1); chk("bp_tna", take_no_action, 4'b0010); chk("bp_pending_clr", cmd_pending, 0);
    tick(1); chk("bp_tna_off", take_no_action, 0);

    // overrun: three dropped commands while one is pending
    cmd_ready = 1'b0;
    dr_cmd(38'h20_0000_00AA, 2, 2);
    repeat (3) dr_cmd(38'h3F_FFFF_FFFF, 2, 2);
    chk("ovr_jdo_kept", jdo, 38'h20_0000_00AA);
    chk("ovr_flag", overrun, 1);
`ifdef DBG_SLAVE_OVERRUN_CNT_EN
    chk("ovr_cnt3", overrun_cnt, 3);
`endif
    strobe_seen = 0;
    cmd_ready = 1'b1;
    tick(1); chk("ovr_ta", take_action, 4'b0010);
    tick(3); chk("ovr_one_strobe", strobe_seen, 1);
    overrun_clr = 1'b1; tick(1); overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
`ifdef DBG_SLAVE_OVERRUN_CNT_EN
    chk("ovr_cnt_clr", overrun_cnt, 0);
`endif

    // IR change while pending
    cmd_ready = 1'b0;
    pulse_uir(2'd0, 2, 3);
    dr_cmd(38'h00_0000_0777, 2, 2);
    pulse_uir(2'd3, 2, 3);
    chk("irchg_cmd_ir", cmd_ir, 0);
    cmd_ready = 1'b1;
    tick(1); chk("irchg_tna", take_no_action, 4'b0001); chk("irchg_ta", take_action, 0);
    dr_cmd(38'h20_0000_0999, 2, 2);
    chk("irchg_next_ta", take_action, 4'b1000); chk("irchg_next_ir", cmd_ir, 3);

    // long level gives a single capture
    strobe_seen = 0;
    dr_cmd(38'h20_0000_0001, 20, 4);
    tick(2);
    chk("long_one_strobe", strobe_seen, 1);
    chk("long_jdo", jdo, 38'h20_0000_0001);

    // reset mid-command
    cmd_ready = 1'b0;
    dr_cmd(38'h20_0000_0002, 2, 2);
    chk("rstmid_pending", cmd_pending, 1);
    #2 reset_n = 1'b0;
    #1 chk("rstmid_pending_now", cmd_pending, 0); chk("rstmid_jdo", jdo, 0);
    tick(2);
    reset_n = 1'b1;
    strobe_seen = 0;
    cmd_ready = 1'b1;
    tick(10);
    chk("rstmid_no_strobe", strobe_seen, 0);

    // randomised traffic
    rnd_ready = 1; rnd_clr = 1;
    for (int i = 0; i < 400; i++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: pulse_uir(IRW'($urandom), $urandom_range(1, 3), $urandom_range(2, 3));
        1: dr_cmd(r[DRW-1:0], $urandom_range(1, 3), $urandom_range(2, 3));
        2: begin
          ir_in = IRW'($urandom); sr = r[DRW-1:0];
          vs_uir = 1'b1; vs_udr = 1'b1;
          tick($urandom_range(1, 3));
          vs_uir = 1'b0; vs_udr = 1'b0;
          tick($urandom_range(2, 3));
        end
        default: tick($urandom_range(1, 4));
      endcase
    end
    rnd_ready = 0; rnd_clr = 0; overrun_clr = 1'b0; cmd_ready = 1'b1;
    tick(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
